bin2bcd_seq: RTL and testbench

Sequential binary-to-8421-BCD converter using the shift-and-add-3 (double-dabble) method, one binary bit per clock. It sits directly upstream of the 8421/Excess-3 code converter. It turns counter or ALU binary results into packed 8421 digits that the converter, or a display driver, consumes. A start/busy/done handshake lets a controller launch one conversion at a time and sample a stable result.

---
 rtl/bin2bcd_seq.sv | 76 +++++++
 tb/tb_bin2bcd_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-packed-BCD converter (shift-and-add-3), one binary bit per clock.
// A start/busy/done handshake launches one conversion at a time; bcd holds between results.
module bin2bcd_seq #(
  parameter int unsigned BIN_W  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int unsigned AccW = 4 * DIGITS;
  localparam int unsigned CntW = $clog2(BIN_W + 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e           state_q;
  logic [BIN_W-1:0] bin_q;
  logic [AccW-1:0]  acc_q;
  logic [CntW-1:0]  cnt_q;
  logic [AccW-1:0]  acc_adj;
  logic [AccW-1:0]  acc_shift;

  // Each digit >= 5 gets +3 inside its own nibble so the following shift carries correctly.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) begin
        acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
    acc_shift = {acc_adj[AccW-2:0], bin_q[BIN_W-1]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      bin_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            bin_q   <= bin;
            acc_q   <= '0;
            cnt_q   <= CntW'(BIN_W);
            busy    <= 1'b1;
            state_q <= StShift;
          end
        end
        StShift: begin
          acc_q <= acc_shift;
          bin_q <= {bin_q[BIN_W-2:0], 1'b0};
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CntW'(1)) begin
            bcd     <= acc_shift;
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: directed cases plus random and exhaustive operands
// compared against a decimal-digit reference model.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  bin;
  logic        busy;
  logic        done;
  logic [11:0] bcd;

  int checks;
  int errors;

  bin2bcd_seq #(
    .BIN_W (8),
    .DIGITS(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .bin  (bin),
    .busy (busy),
    .done (done),
    .bcd  (bcd)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: decimal digits by plain division, packed units-first.
  function automatic logic [11:0] model(input int v);
    logic [11:0] r;
    int          x;
    r = '0;
    x = v;
    for (int i = 0; i < 3; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one conversion and stop in the cycle where done is seen.
  task automatic convert(input logic [7:0] v, output logic [11:0] res, output int busy_cyc,
                         output bit busy_at_done, output bit timeout);
    start = 1'b1;
    bin   = v;
    step();
    start = 1'b0;
    bin   = 8'($urandom);
    busy_cyc = 0;
    timeout  = 1'b1;
    res      = 'x;
    busy_at_done = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        res          = bcd;
        busy_at_done = busy;
        timeout      = 1'b0;
        break;
      end
      if (busy) busy_cyc++;
      step();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    bin   = '0;
    #12;
    checks++;
    if (bcd !== 12'h000 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: bcd=%h done=%b busy=%b want 000/0/0", bcd, done, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    checks++;
    if (bcd !== 12'h000 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: bcd=%h done=%b busy=%b want 000/0/0", bcd, done, busy);
    end
  endtask

  task automatic test_max();
    logic [11:0] res;
    int          bc;
    bit          bad, to;
    convert(8'd255, res, bc, bad, to);
    checks++;
    if (to || res !== model(255)) begin
      errors++;
      $display("FAIL max_value: bcd=%h timeout=%b want %h", res, to, model(255));
    end
    checks++;
    if (bc !== 8 || bad !== 1'b0) begin
      errors++;
      $display("FAIL max_busy: busy_cycles=%0d busy_at_done=%b want 8/0", bc, bad);
    end
    step();
    checks++;
    if (done !== 1'b0 || bcd !== model(255)) begin
      errors++;
      $display("FAIL max_pulse: done=%b bcd=%h want 0/%h", done, bcd, model(255));
    end
  endtask

  task automatic test_boundary();
    int          vals[6] = '{0, 9, 10, 99, 100, 199};
    logic [11:0] res;
    int          bc;
    bit          bad, to;
    foreach (vals[i]) begin
      convert(8'(vals[i]), res, bc, bad, to);
      checks++;
      if (to || res !== model(vals[i])) begin
        errors++;
        $display("FAIL boundary_%0d: bcd=%h want %h", vals[i], res, model(vals[i]));
      end
      step();
    end
  endtask

  task automatic test_sweep();
    logic [11:0] res;
    int          bc;
    bit          bad, to;
    for (int v = 0; v < 256; v++) begin
      convert(8'(v), res, bc, bad, to);
      checks++;
      if (to || res !== model(v) || bc !== 8) begin
        errors++;
        $display("FAIL sweep_%0d: bcd=%h busy_cycles=%0d want %h/8", v, res, bc, model(v));
      end
    end
    step();
  endtask

  task automatic test_random();
    logic [11:0] res;
    int          bc;
    bit          bad, to;
    logic [7:0]  v;
    for (int n = 0; n < 40; n++) begin
      v = 8'($urandom);
      convert(v, res, bc, bad, to);
      checks++;
      if (to || res !== model(int'(v))) begin
        errors++;
        $display("FAIL random_%0d: bcd=%h want %h", v, res, model(int'(v)));
      end
      repeat ($urandom_range(0, 3)) step();
    end
  endtask

  task automatic test_ignore();
    int          ndone;
    logic [11:0] res;
    ndone = 0;
    res   = 'x;
    start = 1'b1;
    bin   = 8'd123;
    step();
    for (int c = 1; c <= 20; c++) begin
      if (c == 2 || c == 5) begin
        start = 1'b1;
        bin   = 8'd7;
      end else begin
        start = 1'b0;
        bin   = 8'($urandom);
      end
      if (done) begin
        ndone++;
        res = bcd;
      end
      step();
    end
    start = 1'b0;
    checks++;
    if (ndone !== 1 || res !== 12'h123) begin
      errors++;
      $display("FAIL ignore_start: dones=%0d bcd=%h want 1/123", ndone, res);
    end
  endtask

  task automatic test_back_to_back();
    logic [11:0] res;
    int          bc, n;
    bit          bad, to;
    convert(8'd42, res, bc, bad, to);
    checks++;
    if (to || res !== 12'h042) begin
      errors++;
      $display("FAIL b2b_first: bcd=%h want 042", res);
    end
    start = 1'b1;
    bin   = 8'd200;
    n     = 0;
    do begin
      step();
      start = 1'b0;
      n++;
      if (!done) begin
        checks++;
        if (bcd !== 12'h042) begin
          errors++;
          $display("FAIL b2b_hold: bcd=%h want 042 at cycle %0d", bcd, n);
        end
      end
    end while (!done && n < 30);
    checks++;
    if (n !== 9 || bcd !== 12'h200) begin
      errors++;
      $display("FAIL b2b_second: cycles=%0d bcd=%h want 9/200", n, bcd);
    end
    step();
  endtask

  task automatic test_reset_mid();
    logic [11:0] res;
    int          bc, seen;
    bit          bad, to;
    convert(8'd17, res, bc, bad, to);
    checks++;
    if (to || res !== 12'h017) begin
      errors++;
      $display("FAIL rstmid_prior: bcd=%h want 017", res);
    end
    step();
    start = 1'b1;
    bin   = 8'd250;
    step();
    start = 1'b0;
    step();
    step();
    step();
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || bcd !== 12'h000 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_async: busy=%b bcd=%h done=%b want 0/000/0", busy, bcd, done);
    end
    #2;
    rst_n = 1'b1;
    seen  = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (done || busy) seen++;
    end
    checks++;
    if (seen !== 0 || bcd !== 12'h000) begin
      errors++;
      $display("FAIL rstmid_nodone: active_cycles=%0d bcd=%h want 0/000", seen, bcd);
    end
    convert(8'd250, res, bc, bad, to);
    checks++;
    if (to || res !== 12'h250) begin
      errors++;
      $display("FAIL rstmid_restart: bcd=%h want 250", res);
    end
    step();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_max();
    test_boundary();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_sweep();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
